// File: rtl/write_back.sv
// Final pipeline stage: retires execute's registered bundle into the register file,
// flags and memory, holding execute while an upper-half write or a store is outstanding.
module write_back #(
  parameter int WIDTH       = 32,
  parameter int REG_BITS    = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_pc,
  input  logic [REG_BITS-1:0]    in_destination_register,
  input  logic                   in_is_writing_memory,
  input  logic [3:0]             in_flags,
  input  logic [WIDTH-1:0]       in_destination_value,
  input  logic                   in_has_upper_value,
  input  logic [WIDTH-1:0]       in_upper_value,
  input  logic [WIDTH-1:0]       in_adjustment_value,
  input  logic                   in_has_flushed,
  output logic                   in_hold,
  output logic [REG_BITS-1:0]    rd_index,
  input  logic [WIDTH-1:0]       rd_value,
  output logic                   reg_we,
  output logic [REG_BITS-1:0]    reg_index,
  output logic [WIDTH-1:0]       reg_value,
  output logic                   flags_we,
  output logic [3:0]             flags_value,
  output logic                   mem_req,
  output logic [WIDTH-1:0]       mem_address,
  output logic [WIDTH-1:0]       mem_data,
  input  logic                   mem_ack,
  output logic                   flushed,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [1:0] {IDLE, UPPER, MEM_WAIT} state_t;

  state_t                 state, state_next;
  logic [REG_BITS-1:0]    upper_index, upper_index_next;
  logic [WIDTH-1:0]       upper_value, upper_value_next;
  logic                   reg_we_next, flags_we_next, mem_req_next, flushed_next, retire;
  logic [REG_BITS-1:0]    reg_index_next;
  logic [WIDTH-1:0]       reg_value_next, mem_address_next, mem_data_next;
  logic [3:0]             flags_value_next;

  // The pc travels with the bundle but nothing is retired from it.
  logic unused_pc;
  assign unused_pc = ^in_pc;

  assign in_hold  = (state != IDLE);
  assign rd_index = in_destination_register;

  always_comb begin
    state_next       = state;
    upper_index_next = upper_index;
    upper_value_next = upper_value;
    reg_we_next      = 1'b0;
    reg_index_next   = reg_index;
    reg_value_next   = reg_value;
    flags_we_next    = 1'b0;
    flags_value_next = flags_value;
    mem_req_next     = mem_req;
    mem_address_next = mem_address;
    mem_data_next    = mem_data;
    flushed_next     = flushed;
    retire           = 1'b0;
    case (state)
      IDLE: begin
        flushed_next = in_has_flushed;
        if (in_valid) begin
          if (in_is_writing_memory) begin
            // Rd==0 marks a cancelled conditional store: it still retires.
            if (in_destination_register != '0) begin
              mem_req_next     = 1'b1;
              mem_address_next = rd_value + in_adjustment_value;
              mem_data_next    = in_destination_value;
              state_next       = MEM_WAIT;
            end else begin
              retire = 1'b1;
            end
          end else begin
            reg_we_next      = (in_destination_register != '0);
            reg_index_next   = in_destination_register;
            reg_value_next   = in_destination_value;
            flags_we_next    = 1'b1;
            flags_value_next = in_flags;
            if (in_has_upper_value) begin
              upper_index_next = in_destination_register + REG_BITS'(1);
              upper_value_next = in_upper_value;
              state_next       = UPPER;
            end else begin
              retire = 1'b1;
            end
          end
        end
      end
      UPPER: begin
        reg_we_next    = (upper_index != '0);
        reg_index_next = upper_index;
        reg_value_next = upper_value;
        retire         = 1'b1;
        state_next     = IDLE;
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          retire       = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      upper_index   <= '0;
      upper_value   <= '0;
      reg_we        <= 1'b0;
      reg_index     <= '0;
      reg_value     <= '0;
      flags_we      <= 1'b0;
      flags_value   <= '0;
      mem_req       <= 1'b0;
      mem_address   <= '0;
      mem_data      <= '0;
      flushed       <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_next;
      upper_index   <= upper_index_next;
      upper_value   <= upper_value_next;
      reg_we        <= reg_we_next;
      reg_index     <= reg_index_next;
      reg_value     <= reg_value_next;
      flags_we      <= flags_we_next;
      flags_value   <= flags_value_next;
      mem_req       <= mem_req_next;
      mem_address   <= mem_address_next;
      mem_data      <= mem_data_next;
      flushed       <= flushed_next;
      retired_count <= retired_count + COUNT_WIDTH'(retire);
    end
  end

endmodule
